pipelined_compare_unit: RTL and testbench

- Parametrised, pipelined successor to the single-cycle 32-bit not-equal checker.
- Compares two WIDTH-bit operands under a selectable mode: EQ, NE, LT, LTU, GE or GEU.
- Two-stage pipeline with valid/ready handshake, a tag passthrough and a saturating true-result counter.
- Sits between the decode/bypass stage and branch resolution in the CPU pipeline.

---
 rtl/pipelined_compare_unit.sv | 142 ++++++++++++++
 tb/tb_pipelined_compare_unit.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_compare_unit.sv
`timescale 1ns/1ps
// Two-stage pipelined comparator: per-chunk equality / unsigned less-than in stage 1,
// priority merge and mode select in stage 2, with valid/ready flow control and a true-result counter.
module pipelined_compare_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] true_count
);

    localparam int NCH = WIDTH / CHUNK;

    localparam logic [2:0] MODE_EQ  = 3'd0;
    localparam logic [2:0] MODE_NE  = 3'd1;
    localparam logic [2:0] MODE_LT  = 3'd2;
    localparam logic [2:0] MODE_LTU = 3'd3;
    localparam logic [2:0] MODE_GE  = 3'd4;
    localparam logic [2:0] MODE_GEU = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic stall;
    logic advance;
    logic out_xfer;

    // Stalling only when a valid result is blocked lets bubbles in stage 2 be overwritten.
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;
    assign out_xfer = out_valid & out_ready;

    logic [NCH-1:0] ne_c;
    logic [NCH-1:0] lt_c;

    always_comb begin
        ne_c = '0;
        lt_c = '0;
        for (int i = 0; i < NCH; i++) begin
            ne_c[i] = |(in_a[i*CHUNK +: CHUNK] ^ in_b[i*CHUNK +: CHUNK]);
            lt_c[i] = in_a[i*CHUNK +: CHUNK] < in_b[i*CHUNK +: CHUNK];
        end
    end

    logic             s1_valid;
    logic [NCH-1:0]   s1_ne;
    logic [NCH-1:0]   s1_lt;
    logic             s1_sign_a;
    logic             s1_sign_b;
    logic [2:0]       s1_mode;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_ne     <= '0;
            s1_lt     <= '0;
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
            s1_mode   <= '0;
            s1_tag    <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_ne     <= ne_c;
            s1_lt     <= lt_c;
            s1_sign_a <= in_a[WIDTH-1];
            s1_sign_b <= in_b[WIDTH-1];
            s1_mode   <= in_mode;
            s1_tag    <= in_tag;
        end
    end

    logic s2_ne;
    logic s2_ltu;
    logic s2_lt;
    logic s2_result;
    logic s2_illegal;

    always_comb begin
        s2_ltu = 1'b0;
        // The most significant differing chunk decides the unsigned ordering.
        for (int i = 0; i < NCH; i++) begin
            if (s1_ne[i]) begin
                s2_ltu = s1_lt[i];
            end
        end
        s2_ne      = |s1_ne;
        s2_lt      = (s1_sign_a != s1_sign_b) ? s1_sign_a : s2_ltu;
        s2_result  = 1'b0;
        s2_illegal = 1'b0;
        case (s1_mode)
            MODE_EQ:  s2_result = ~s2_ne;
            MODE_NE:  s2_result = s2_ne;
            MODE_LT:  s2_result = s2_lt;
            MODE_LTU: s2_result = s2_ltu;
            MODE_GE:  s2_result = ~s2_lt;
            MODE_GEU: s2_result = ~s2_ltu;
            default:  s2_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_result  <= 1'b0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (advance) begin
            out_valid   <= s1_valid;
            out_result  <= s2_result;
            out_tag     <= s1_tag;
            out_illegal <= s2_illegal;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            true_count <= '0;
        end else if (cnt_clear) begin
            true_count <= '0;
        end else if (out_xfer && out_result && (true_count != CNT_MAX)) begin
            true_count <= true_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipelined_compare_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for pipelined_compare_unit: a behavioural compare model feeds an expected queue,
// a negedge monitor pops and compares on every output transfer.
module tb_pipelined_compare_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic        cnt_clear = 1'b0;
    logic [3:0]  true_count;

    pipelined_compare_unit #(
        .WIDTH(32), .CHUNK(8), .TAG_W(5), .CNT_W(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal),
        .cnt_clear(cnt_clear), .true_count(true_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       res;
        logic       ill;
        logic [4:0] tag;
        int         cyc;
        bit         lat;
    } exp_t;

    typedef struct {
        logic       res;
        logic       ill;
        logic [4:0] tag;
        int         cyc;
    } got_t;

    exp_t sb[$];
    got_t got_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_en = 1'b0;
    bit   rnd_done = 1'b0;
    exp_t mon_e;
    got_t mon_g;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [1:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        case (m)
            3'd0: return {1'b0, a == b};
            3'd1: return {1'b0, a != b};
            3'd2: return {1'b0, $signed(a) < $signed(b)};
            3'd3: return {1'b0, a < b};
            3'd4: return {1'b0, $signed(a) >= $signed(b)};
            3'd5: return {1'b0, a >= b};
            default: return 2'b10;
        endcase
    endfunction

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got tag=%0d res=%0b, required no output", out_tag, out_result);
            end else begin
                mon_e = sb.pop_front();
                if (out_result !== mon_e.res || out_illegal !== mon_e.ill || out_tag !== mon_e.tag) begin
                    errors++;
                    $display("FAIL output: got res=%0b ill=%0b tag=%0d, required res=%0b ill=%0b tag=%0d",
                             out_result, out_illegal, out_tag, mon_e.res, mon_e.ill, mon_e.tag);
                end
                if (mon_e.lat) begin
                    checks++;
                    if (cyc - mon_e.cyc !== 2) begin
                        errors++;
                        $display("FAIL latency tag=%0d: got %0d cycles, required 2", out_tag, cyc - mon_e.cyc);
                    end
                end
            end
            mon_g.res = out_result;
            mon_g.ill = out_illegal;
            mon_g.tag = out_tag;
            mon_g.cyc = cyc;
            got_q.push_back(mon_g);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m, input logic [4:0] tag);
        exp_t       e;
        logic [1:0] r;
        bit         acc;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_mode = m;
        in_tag = tag;
        r = model(a, b, m);
        acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clock);
            if (in_ready) begin
                e.res = r[0];
                e.ill = r[1];
                e.tag = tag;
                e.cyc = cyc;
                e.lat = lat_en;
                sb.push_back(e);
                acc = 1'b1;
            end
            @(posedge clock); #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_accept tag=%0d: in_ready stayed 0, required 1", tag);
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clock);
            if (sb.size() == 0) ok = 1'b1;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 1'b0 || out_tag !== 5'd0 || out_illegal !== 1'b0 || true_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_values: got valid=%0b res=%0b tag=%0d ill=%0b cnt=%0d, required all 0",
                     out_valid, out_result, out_tag, out_illegal, true_count);
        end
        reset_n = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || true_count !== 4'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got valid=%0b in_ready=%0b cnt=%0d, required 0 1 0",
                     out_valid, in_ready, true_count);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        int n0;
        n0 = got_q.size();
        lat_en = 1'b1;
        send(32'h0000_0005, 32'h0000_0005, 3'd0, 5'd3);
        send(32'h8000_0000, 32'h0000_0001, 3'd2, 5'd4);
        send(32'h8000_0000, 32'h0000_0001, 3'd3, 5'd5);
        in_valid = 1'b0;
        wait_drain(ok);
        lat_en = 1'b0;
        checks++;
        if (!ok || got_q.size() != n0 + 3) begin
            errors++;
            $display("FAIL basic_count: got %0d outputs, required 3", got_q.size() - n0);
        end else begin
            checks++;
            if (got_q[n0].res !== 1'b1 || got_q[n0+1].res !== 1'b1 || got_q[n0+2].res !== 1'b0) begin
                errors++;
                $display("FAIL basic_results: got %0b %0b %0b, required 1 1 0",
                         got_q[n0].res, got_q[n0+1].res, got_q[n0+2].res);
            end
            checks++;
            if (got_q[n0].tag !== 5'd3 || got_q[n0+1].tag !== 5'd4 || got_q[n0+2].tag !== 5'd5) begin
                errors++;
                $display("FAIL basic_tags: got %0d %0d %0d, required 3 4 5",
                         got_q[n0].tag, got_q[n0+1].tag, got_q[n0+2].tag);
            end
            checks++;
            if (got_q[n0+1].cyc != got_q[n0].cyc + 1 || got_q[n0+2].cyc != got_q[n0].cyc + 2) begin
                errors++;
                $display("FAIL basic_back_to_back: got cycles %0d %0d %0d, required consecutive",
                         got_q[n0].cyc, got_q[n0+1].cyc, got_q[n0+2].cyc);
            end
        end
    endtask

    task automatic test_chunk();
        bit ok;
        int n0;
        n0 = got_q.size();
        lat_en = 1'b1;
        send(32'h0100_0000, 32'h00FF_FFFF, 3'd5, 5'd6);
        send(32'h0100_0000, 32'h00FF_FFFF, 3'd1, 5'd7);
        send(32'hFFFF_FFFF, 32'h0000_0000, 3'd4, 5'd8);
        in_valid = 1'b0;
        wait_drain(ok);
        lat_en = 1'b0;
        checks++;
        if (!ok || got_q.size() != n0 + 3) begin
            errors++;
            $display("FAIL chunk_count: got %0d outputs, required 3", got_q.size() - n0);
        end else begin
            checks++;
            if (got_q[n0].res !== 1'b1 || got_q[n0+1].res !== 1'b1 || got_q[n0+2].res !== 1'b0) begin
                errors++;
                $display("FAIL chunk_results: got %0b %0b %0b, required 1 1 0",
                         got_q[n0].res, got_q[n0+1].res, got_q[n0+2].res);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n0;
        n0 = got_q.size();
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(32'h1234_0000 + i, 32'h1234_0002, 3'd1, 5'(10 + i));
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clock);
                #1;
                out_ready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clock);
                    checks++;
                    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_in_ready cycle %0d: got out_valid=%0b in_ready=%0b, required 1 0",
                                 c, out_valid, in_ready);
                    end
                    @(posedge clock); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain(ok);
        checks++;
        if (!ok || got_q.size() != n0 + 6) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs, required 6", got_q.size() - n0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_q[n0+i].tag !== 5'(10 + i) || got_q[n0+i].res !== (i != 2)) begin
                    errors++;
                    $display("FAIL bp_order idx %0d: got tag=%0d res=%0b, required tag=%0d res=%0b",
                             i, got_q[n0+i].tag, got_q[n0+i].res, 10 + i, i != 2);
                end
            end
        end
    endtask

    task automatic test_reserved();
        bit ok;
        int n0;
        cnt_clear = 1'b1;
        @(posedge clock); #1;
        cnt_clear = 1'b0;
        n0 = got_q.size();
        send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd0, 5'd1);
        send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd7, 5'd2);
        send(32'h0000_0001, 32'h0000_0002, 3'd6, 5'd3);
        in_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || got_q.size() != n0 + 3) begin
            errors++;
            $display("FAIL reserved_count: got %0d outputs, required 3", got_q.size() - n0);
        end else begin
            checks++;
            if (got_q[n0+1].ill !== 1'b1 || got_q[n0+1].res !== 1'b0 ||
                got_q[n0+2].ill !== 1'b1 || got_q[n0+2].res !== 1'b0) begin
                errors++;
                $display("FAIL reserved_flags: got ill=%0b%0b res=%0b%0b, required ill=11 res=00",
                         got_q[n0+1].ill, got_q[n0+2].ill, got_q[n0+1].res, got_q[n0+2].res);
            end
        end
        checks++;
        if (true_count !== 4'd1) begin
            errors++;
            $display("FAIL reserved_count_hold: got true_count=%0d, required 1", true_count);
        end
    endtask

    task automatic test_counter();
        bit ok;
        bit seen;
        cnt_clear = 1'b1;
        @(posedge clock); #1;
        cnt_clear = 1'b0;
        checks++;
        if (true_count !== 4'd0) begin
            errors++;
            $display("FAIL cnt_clear_idle: got %0d, required 0", true_count);
        end
        for (int i = 0; i < 17; i++)
            send(32'(i * 7), 32'(i * 7), 3'd0, 5'(i));
        in_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok || true_count !== 4'd15) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d (drained=%0b), required 15", true_count, ok);
        end
        send(32'h5, 32'h9, 3'd3, 5'd20);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clock);
            if (out_valid) begin
                cnt_clear = 1'b1;
                seen = 1'b1;
            end
        end
        @(posedge clock); #1;
        cnt_clear = 1'b0;
        checks++;
        if (!seen || true_count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cnt_clear_priority: got cnt=%0d seen=%0b out_valid=%0b, required 0 1 0",
                     true_count, seen, out_valid);
        end
    endtask

    task automatic test_random();
        bit          ok;
        int          n0;
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        n0 = got_q.size();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clock); #1;
                    end
                    a = $urandom;
                    case ($urandom_range(0, 3))
                        0: b = a;
                        1: begin
                            b = a;
                            k = $urandom_range(0, 3);
                            b[k*8 +: 8] = 8'($urandom);
                        end
                        2: b = $urandom;
                        default: b = a ^ 32'h8000_0000;
                    endcase
                    send(a, b, 3'($urandom_range(0, 7)), 5'(i));
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clock); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clock);
                    checks++;
                    if (in_ready !== ~(out_valid & ~out_ready)) begin
                        errors++;
                        $display("FAIL rnd_in_ready: got %0b with out_valid=%0b out_ready=%0b",
                                 in_ready, out_valid, out_ready);
                    end
                end
            end
        join
        out_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || got_q.size() != n0 + 40) begin
            errors++;
            $display("FAIL rnd_count: got %0d outputs, required 40", got_q.size() - n0);
        end
    endtask

    task automatic test_reset_midstream();
        int n0;
        out_ready = 1'b1;
        send(32'h1, 32'h1, 3'd0, 5'd21);
        send(32'h2, 32'h2, 3'd0, 5'd22);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: got out_valid=%0b, required 1", out_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got out_valid=%0b, required 0", out_valid);
        end
        sb.delete();
        n0 = got_q.size();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        checks++;
        if (got_q.size() != n0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_discard: got %0d outputs after release, out_valid=%0b, required 0 0",
                     got_q.size() - n0, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chunk();
        test_backpressure();
        test_reserved();
        test_counter();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
